flasher_lamp_driver: RTL and testbench
======================================

# flasher_lamp_driver

Sequential lamp datapath for the bound flasher. It owns the 16-lamp register that the next-state logic reads, and it advances one lamp per step in the direction set by the current state code. It also debounces the raw flick button into the clean `flick` level that the next-state logic consumes. It sits between the state register and the lamp pins, and closes the loop: state code in, lamp vector and flick out.

## Interface
- `N_LAMP`, 16, number of lamps (thermometer width).
- `TICK_DIV`, 1, clock cycles per lamp step (≥1); 1 means a step every cycle.
- `DEB_CYCLES`, 4, consecutive stable samples needed to change `flick` (≥1).

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `current`  in  3  present state code (0..6; 7 is illegal).
- `flick_raw`  in  1  undebounced flick button.
- `lamp`  out  N_LAMP  registered lamp vector, thermometer-coded from bit 0.
- `level`  out  $clog2(N_LAMP+1)  number of lamps lit (0..N_LAMP).
- `step`  out  1  one-cycle pulse, high in the cycle a new `lamp` value first appears.
- `flick`  out  1  debounced flick level.

## Operation
- Direction by `current`:
  - 0 (idle) and 7 (illegal): clear, level ← 0.
  - 1, 3, 5: up, level ← min(level+1, N_LAMP).
  - 2, 4, 6: down, level ← max(level−1, 0).
- Prescaler `pcnt` counts 0..TICK_DIV−1 and wraps. `tick` = (pcnt == TICK_DIV−1).
- In states 0/7, `pcnt` is held at 0 and the clear is applied every cycle, not gated by `tick`.
- Up/down updates happen only on `tick`. Saturation at N_LAMP or 0 holds the level; it does not wrap.
- No memory of the previous state. A direction change mid-sequence (kickback 3→2 or 5→4) takes effect on the next tick from the current level.
- `lamp[i]` = 1 iff i < level. `lamp` and `level` are registered together and never disagree.
- `step` ← 1 iff the registered level changes on this edge. A saturated step or a clear from level 0 gives `step` = 0.
- Debounce (sub-module):
  - `flick_raw` passes through a 2-flop synchronizer.
  - A counter increments while the synchronized value ≠ `flick` and resets to 0 when they are equal.
  - When the count reaches DEB_CYCLES, `flick` takes the synchronized value and the counter clears.
- Milestones the next-state logic depends on: level 5 = 0x001F, level 6 = 0x003F, level 11 = 0x07FF, level 16 = 0xFFFF.

## Timing
- Reset values: `lamp` = 0, `level` = 0, `step` = 0, `flick` = 0, pcnt = 0, debounce counter = 0, synchronizer = 0.
- `rst` overrides all other inputs on the same edge.
- Latency: a tick sampled at edge k gives the new `lamp`/`level`/`step` after edge k.
- First step after leaving state 0 occurs on the TICK_DIV-th edge in the new state.
- `flick` latency from a stable `flick_raw` change: 2 (synchronizer) + DEB_CYCLES edges.
- An isolated pulse shorter than DEB_CYCLES cycles never reaches `flick`.
- Reset mid-sequence: lamps go dark on the next edge. Counting restarts from 0.

## Structure
- Shared package `flasher_pkg`:
  - state-code constants ST_IDLE = 0, ST_UP6 = 1, ST_DN0A = 2, ST_UP11 = 3, ST_DN5 = 4, ST_UP16 = 5, ST_DN0B = 6;
  - STATE_W = 3;
  - default N_LAMP;
  - milestone constants LAMP_5, LAMP_6, LAMP_11, LAMP_ALL.
- One sub-module, `flick_debounce` (synchronizer plus stable-count filter), parameterized by DEB_CYCLES.
- Prescaler, level counter and thermometer decode stay in the top module.

## Test plan
- Reset: assert `rst` for 2 cycles with `current` = 1 and `flick_raw` = 1 → `lamp` = 0x0000, `level` = 0, `step` = 0, `flick` = 0.
- TICK_DIV = 1, `current` 0→1 held 6 cycles → `lamp` goes 0x0001, 0x0003, 0x0007, 0x000F, 0x001F, 0x003F, with `step` = 1 each cycle.
- `current` = 5 held 20 cycles from 0 → saturates at 0xFFFF with `level` = 16. `step` falls after the 16th change and `lamp` holds.
- From 0x07FF, `current` = 2 → reaches 0x0000 after 11 edges and stays there with `step` = 0. Then `current` = 4 from 0xFFFF, switched to 3 when `lamp` = 0x00FF → next value 0x01FF.
- TICK_DIV = 4, `current` 0→3 → first change (0x0001) on the 4th edge, then every 4 edges. `current` back to 0 → `lamp` = 0 on the next edge.
- DEB_CYCLES = 4:
  - a 3-cycle high glitch on `flick_raw` → `flick` stays 0;
  - `flick_raw` held high → `flick` = 1 exactly 6 edges after the rising sample, and returns to 0 6 edges after `flick_raw` falls.

Source files
------------

// File: rtl/flasher_pkg.sv
`default_nettype none
// ============================================================================
// flasher_pkg : shared state codes, lamp milestones and direction decode
// Rev 1.0
// ============================================================================
package flasher_pkg;

   localparam int STATE_W    = 3;
   localparam int N_LAMP_DEF = 16;

   localparam logic [STATE_W-1:0] ST_IDLE = 3'd0;
   localparam logic [STATE_W-1:0] ST_UP6  = 3'd1;
   localparam logic [STATE_W-1:0] ST_DN0A = 3'd2;
   localparam logic [STATE_W-1:0] ST_UP11 = 3'd3;
   localparam logic [STATE_W-1:0] ST_DN5  = 3'd4;
   localparam logic [STATE_W-1:0] ST_UP16 = 3'd5;
   localparam logic [STATE_W-1:0] ST_DN0B = 3'd6;

   localparam logic [15:0] LAMP_5   = 16'h001F;
   localparam logic [15:0] LAMP_6   = 16'h003F;
   localparam logic [15:0] LAMP_11  = 16'h07FF;
   localparam logic [15:0] LAMP_ALL = 16'hFFFF;

   typedef enum logic [1:0] {
      DIR_CLEAR = 2'd0,
      DIR_UP    = 2'd1,
      DIR_DOWN  = 2'd2
   } dir_e;

   // Odd codes climb, even non-zero codes descend; idle and the illegal 7 clear.
   function automatic dir_e decode_dir(input logic [STATE_W-1:0] code);
      dir_e d;
      case (code)
         ST_UP6, ST_UP11, ST_UP16:  d = DIR_UP;
         ST_DN0A, ST_DN5, ST_DN0B:  d = DIR_DOWN;
         default:                   d = DIR_CLEAR;
      endcase
      return d;
   endfunction

endpackage
`default_nettype wire

// File: rtl/flick_debounce.sv
`default_nettype none
// ============================================================================
// flick_debounce : 2-flop synchronizer followed by a stable-count filter
// Rev 1.0
// ============================================================================
module flick_debounce #(
   parameter int DEB_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic flick_raw,
   output logic flick
);

   localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

   logic [1:0]       sync_q;
   logic [CNT_W-1:0] cnt;
   logic             synced;

   assign synced = sync_q[1];

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= 2'b00;
         cnt    <= '0;
         flick  <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], flick_raw};
         if (synced == flick) begin
            cnt <= '0;
         end else if (cnt == CNT_W'(DEB_CYCLES - 1)) begin
            // This edge is the DEB_CYCLES-th consecutive disagreeing sample.
            flick <= synced;
            cnt   <= '0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/flasher_lamp_driver.sv
`default_nettype none
// ============================================================================
// flasher_lamp_driver : prescaled up/down/clear lamp level with thermometer out
// Rev 1.0
// ============================================================================
module flasher_lamp_driver
   import flasher_pkg::*;
#(
   parameter int N_LAMP     = N_LAMP_DEF,
   parameter int TICK_DIV   = 1,
   parameter int DEB_CYCLES = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [STATE_W-1:0]           current,
   input  logic                         flick_raw,
   output logic [N_LAMP-1:0]            lamp,
   output logic [$clog2(N_LAMP+1)-1:0]  level,
   output logic                         step,
   output logic                         flick
);

   localparam int LVL_W = $clog2(N_LAMP + 1);
   localparam int PC_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   dir_e              dir;
   logic [PC_W-1:0]   pcnt;
   logic [PC_W-1:0]   pcnt_nxt;
   logic              tick;
   logic [LVL_W-1:0]  level_nxt;
   logic [N_LAMP-1:0] lamp_nxt;

   always_comb begin
      dir       = decode_dir(current);
      tick      = (pcnt == PC_W'(TICK_DIV - 1));
      pcnt_nxt  = pcnt + PC_W'(1);
      level_nxt = level;
      case (dir)
         DIR_UP: begin
            if (tick && (level != LVL_W'(N_LAMP)))
               level_nxt = level + LVL_W'(1);
         end
         DIR_DOWN: begin
            if (tick && (level != '0))
               level_nxt = level - LVL_W'(1);
         end
         default: begin
            level_nxt = '0;
         end
      endcase
      // Clearing states hold the prescaler so the first step lands TICK_DIV edges in.
      if ((dir == DIR_CLEAR) || tick)
         pcnt_nxt = '0;
   end

   for (genvar i = 0; i < N_LAMP; i++) begin : g_therm
      assign lamp_nxt[i] = (level_nxt > LVL_W'(i));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pcnt  <= '0;
         level <= '0;
         lamp  <= '0;
         step  <= 1'b0;
      end else begin
         pcnt  <= pcnt_nxt;
         level <= level_nxt;
         lamp  <= lamp_nxt;
         step  <= (level_nxt != level);
      end
   end

   flick_debounce #(
      .DEB_CYCLES (DEB_CYCLES)
   ) u_debounce (
      .clk       (clk),
      .rst       (rst),
      .flick_raw (flick_raw),
      .flick     (flick)
   );

endmodule
`default_nettype wire

// File: tb/tb_flasher_lamp_driver.sv
`default_nettype none
// ============================================================================
// tb_flasher_lamp_driver : directed scoreboard bench, TICK_DIV 1 and 4 instances
// Rev 1.0
// ============================================================================
module tb_flasher_lamp_driver;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  current;
   logic [2:0]  cur4;
   logic        flick_raw;

   logic [15:0] lamp,  lamp4;
   logic [4:0]  level, level4;
   logic        step,  step4;
   logic        flick, flick4;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int          sel;
      logic [31:0] exp;
      string       tag;
   } sb_t;

   sb_t sb[$];

   always #5 clk = ~clk;

   flasher_lamp_driver #(.N_LAMP(16), .TICK_DIV(1), .DEB_CYCLES(4)) dut (
      .clk(clk), .rst(rst), .current(current), .flick_raw(flick_raw),
      .lamp(lamp), .level(level), .step(step), .flick(flick)
   );

   flasher_lamp_driver #(.N_LAMP(16), .TICK_DIV(4), .DEB_CYCLES(4)) dut4 (
      .clk(clk), .rst(rst), .current(cur4), .flick_raw(flick_raw),
      .lamp(lamp4), .level(level4), .step(step4), .flick(flick4)
   );

   function automatic logic [31:0] observe(input int sel);
      case (sel)
         0:       return 32'(lamp);
         1:       return 32'(level);
         2:       return 32'(step);
         3:       return 32'(flick);
         4:       return 32'(lamp4);
         5:       return 32'(level4);
         6:       return 32'(step4);
         7:       return 32'(flick4);
         default: return 32'hDEAD_BEEF;
      endcase
   endfunction

   task automatic push(input int sel, input logic [31:0] exp, input string tag);
      sb_t e;
      e.sel = sel;
      e.exp = exp;
      e.tag = tag;
      sb.push_back(e);
   endtask

   // Expected lamp image for a given level, built by shifting rather than comparing.
   function automatic logic [15:0] therm(input int lv);
      logic [31:0] t;
      t = (32'd1 << lv) - 32'd1;
      return t[15:0];
   endfunction

   task automatic exp_main(input int lv, input logic st, input string tag);
      push(0, 32'(therm(lv)), {tag, ".lamp"});
      push(1, 32'(lv),        {tag, ".level"});
      push(2, 32'(st),        {tag, ".step"});
   endtask

   task automatic exp_t4(input int lv, input logic st, input string tag);
      push(4, 32'(therm(lv)), {tag, ".lamp4"});
      push(5, 32'(lv),        {tag, ".level4"});
      push(6, 32'(st),        {tag, ".step4"});
   endtask

   task automatic exp_flick(input logic f, input string tag);
      push(3, 32'(f), {tag, ".flick"});
      push(7, 32'(f), {tag, ".flick4"});
   endtask

   task automatic drain();
      sb_t         e;
      logic [31:0] got;
      while (sb.size() > 0) begin
         e   = sb.pop_front();
         got = observe(e.sel);
         checks++;
         assert (got === e.exp) else begin
            errors++;
            $error("FAIL %s got %h exp %h", e.tag, got, e.exp);
         end
      end
   endtask

   task automatic clk_check();
      @(posedge clk);
      #1;
      drain();
   endtask

   initial begin
      int lv;
      rst       = 1'b1;
      current   = 3'd1;
      cur4      = 3'd1;
      flick_raw = 1'b1;

      // Reset held two edges while every input pushes against it.
      @(posedge clk);
      exp_main(0, 1'b0, "reset");
      exp_t4(0, 1'b0, "reset");
      exp_flick(1'b0, "reset");
      clk_check();

      rst       = 1'b0;
      current   = 3'd0;
      cur4      = 3'd0;
      flick_raw = 1'b0;
      exp_main(0, 1'b0, "idle_from0");
      clk_check();

      // Climb 0 -> 6 one lamp per edge.
      current = 3'd1;
      for (int k = 1; k <= 6; k++) begin
         exp_main(k, 1'b1, $sformatf("up6_%0d", k));
         clk_check();
      end
      current = 3'd0;
      exp_main(0, 1'b1, "clear6");
      clk_check();

      // Climb to full and saturate.
      current = 3'd5;
      for (int k = 1; k <= 20; k++) begin
         lv = (k > 16) ? 16 : k;
         exp_main(lv, (k <= 16), $sformatf("up16_%0d", k));
         clk_check();
      end
      current = 3'd0;
      exp_main(0, 1'b1, "clear16");
      clk_check();

      current = 3'd3;
      for (int k = 1; k <= 11; k++) begin
         exp_main(k, 1'b1, $sformatf("up11_%0d", k));
         clk_check();
      end

      // Descend from 0x07FF and hold at zero.
      current = 3'd2;
      for (int k = 1; k <= 13; k++) begin
         lv = (k > 11) ? 0 : 11 - k;
         exp_main(lv, (k <= 11), $sformatf("dn0_%0d", k));
         clk_check();
      end

      current = 3'd5;
      for (int k = 1; k <= 16; k++) begin
         exp_main(k, 1'b1, $sformatf("refill_%0d", k));
         clk_check();
      end

      // Descend to 0x00FF then kick back up and down again.
      current = 3'd4;
      for (int k = 1; k <= 8; k++) begin
         exp_main(16 - k, 1'b1, $sformatf("dn5_%0d", k));
         clk_check();
      end
      current = 3'd3;
      exp_main(9, 1'b1, "kick_up");
      clk_check();
      current = 3'd2;
      exp_main(8, 1'b1, "kick_dn");
      clk_check();

      current = 3'd7;
      exp_main(0, 1'b1, "illegal_clr");
      clk_check();
      exp_main(0, 1'b0, "illegal_hold");
      clk_check();

      // Reset in the middle of a climb.
      current = 3'd1;
      for (int k = 1; k <= 3; k++) begin
         exp_main(k, 1'b1, $sformatf("pre_rst_%0d", k));
         clk_check();
      end
      rst = 1'b1;
      exp_main(0, 1'b0, "mid_rst");
      clk_check();
      rst = 1'b0;
      exp_main(1, 1'b1, "post_rst");
      clk_check();
      current = 3'd0;
      exp_main(0, 1'b1, "post_rst_clr");
      clk_check();

      // Prescaled instance: one step every fourth edge.
      cur4 = 3'd3;
      for (int k = 1; k <= 12; k++) begin
         exp_t4(k / 4, (k % 4 == 0), $sformatf("div4_%0d", k));
         clk_check();
      end
      cur4 = 3'd0;
      exp_t4(0, 1'b1, "div4_clr");
      clk_check();

      // Three-cycle glitch must be filtered.
      flick_raw = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         if (k == 4) flick_raw = 1'b0;
         exp_flick(1'b0, $sformatf("glitch_%0d", k));
         clk_check();
      end

      flick_raw = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         exp_flick((k >= 6), $sformatf("rise_%0d", k));
         clk_check();
      end
      flick_raw = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         exp_flick((k < 6), $sformatf("fall_%0d", k));
         clk_check();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
